// File: rtl/bcd_conv_pkg.sv
// Shared constants and FSM state type for the BCD-to-binary converter.
//   DEFAULT_DIGITS : default number of packed BCD digits at the input
//   DEFAULT_BIN_W  : default binary result width (2**BIN_W > 10**DIGITS - 1)
//   state_t        : converter FSM states IDLE, SHIFT, DONE
package bcd_conv_pkg;

    localparam int unsigned DEFAULT_DIGITS = 3;
    localparam int unsigned DEFAULT_BIN_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : bcd_conv_pkg

// File: rtl/bcd_sub_three_cell.sv
// Per-digit correction for reverse double-dabble: a digit that picked up
// the weight-8 bit from the digit above during a right shift really holds
// 5 in that position, so 3 is removed to keep it a valid BCD digit.
//   digit     : 4-bit BCD digit after the shift
//   corrected : digit - 3 when digit >= 8, otherwise digit unchanged
module bcd_sub_three_cell (
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    assign corrected = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule : bcd_sub_three_cell

// File: rtl/bcd_to_binary_converter.sv
// Multi-cycle packed-BCD to binary converter (reverse double-dabble).
//   clk        : clock, rising-edge active
//   reset      : synchronous active-high reset
//   start      : conversion request, sampled only in IDLE
//   BCD_In     : packed BCD input, digit 0 in bits [3:0]
//   Binary_Out : binary result of the last completed conversion (held)
//   busy       : high while in SHIFT or DONE
//   done       : one-cycle pulse when Binary_Out/error are updated
//   error      : a digit of the captured input exceeded 9 (valid with done)
module bcd_to_binary_converter
    import bcd_conv_pkg::*;
#(
    parameter int unsigned DIGITS = DEFAULT_DIGITS,
    parameter int unsigned BIN_W  = DEFAULT_BIN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   BCD_In,
    output logic [BIN_W-1:0]      Binary_Out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_reg_q, err_reg_d;
    logic [BIN_W-1:0]   out_d;
    logic               busy_d, done_d, error_d;

    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bcd_fix;
    logic [BIN_W-1:0]   bin_shift;
    logic               digit_bad;

    // One right shift of the combined {bcd, bin} register, zero into the MSB
    assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
    assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};

    // Digit correction applied to the freshly shifted BCD field
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_cell
        bcd_sub_three_cell u_cell (
            .digit     (bcd_shift[4*g +: 4]),
            .corrected (bcd_fix[4*g +: 4])
        );
    end

    // Flag any non-decimal digit on the input being captured
    always_comb begin
        digit_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (BCD_In[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        err_reg_d = err_reg_q;
        out_d     = Binary_Out;
        error_d   = error;
        busy_d    = busy;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_d     = BCD_In;
                    bin_d     = '0;
                    cnt_d     = '0;
                    err_reg_d = digit_bad;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = bcd_fix;
                bin_d = bin_shift;
                cnt_d = cnt_q + CNT_W'(1);
                // Last iteration: publish the result straight from the shift
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    out_d   = bin_shift;
                    error_d = err_reg_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            err_reg_q  <= 1'b0;
            Binary_Out <= '0;
            error      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            err_reg_q  <= err_reg_d;
            Binary_Out <= out_d;
            error      <= error_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule : bcd_to_binary_converter

// File: tb/tb_bcd_to_binary_converter.sv
// Self-checking bench for bcd_to_binary_converter (DIGITS=3, BIN_W=10).
module tb_bcd_to_binary_converter;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk;
    logic              reset;
    logic              start;
    logic [11:0]       BCD_In;
    logic [BIN_W-1:0]  Binary_Out;
    logic              busy;
    logic              done;
    logic              error;

    int vectors;
    int miscompares;

    bcd_to_binary_converter #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .BCD_In     (BCD_In),
        .Binary_Out (Binary_Out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decimal value of a packed BCD word
    function automatic int bcd_value(input logic [11:0] b);
        int s;
        int w;
        s = 0;
        w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            s += int'(b[4*i +: 4]) * w;
            w *= 10;
        end
        return s;
    endfunction

    function automatic bit bcd_bad(input logic [11:0] b);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: a request accepted at edge t0 keeps busy through
    // edge t0+BIN_W, done appears after edge t0+BIN_W, and a new request
    // can only be taken when the previous window has fully closed.
    bit model_valid = 1'b0;
    int edge_n      = 0;
    bit have_job    = 1'b0;
    int t0          = 0;
    int job_val     = 0;
    bit job_err     = 1'b0;
    bit idle_now;
    bit m_busy      = 1'b0;
    bit m_done      = 1'b0;
    bit m_err       = 1'b0;
    int m_out       = 0;
    bit m_out_known = 1'b1;

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            have_job    = 1'b0;
            m_busy      = 1'b0;
            m_done      = 1'b0;
            m_err       = 1'b0;
            m_out       = 0;
            m_out_known = 1'b1;
            model_valid = 1'b1;
        end else if (model_valid) begin
            idle_now = !(have_job && (edge_n - 1) >= t0 && (edge_n - 1) <= t0 + BIN_W);
            if (idle_now && start) begin
                have_job = 1'b1;
                t0       = edge_n;
                job_val  = bcd_value(BCD_In);
                job_err  = bcd_bad(BCD_In);
            end
            m_busy = have_job && edge_n >= t0 && edge_n <= t0 + BIN_W;
            m_done = have_job && edge_n == t0 + BIN_W;
            if (m_done) begin
                m_err       = job_err;
                m_out       = job_val;
                m_out_known = !job_err;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (model_valid) begin
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
            check("error", int'(error), int'(m_err));
            if (m_out_known) check("binary_out", int'(Binary_Out), m_out);
        end
    end

    // Pulse start for one edge and wait (bounded) for done
    task automatic convert(input logic [11:0] bcd, input int exp_val,
                           input bit chk_val, input bit exp_err, input string tag);
        int lat;
        @(negedge clk);
        BCD_In = bcd;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, BIN_W + 1);
        if (chk_val) check({tag, "_value"}, int'(Binary_Out), exp_val);
        check({tag, "_error"}, int'(error), int'(exp_err));
    endtask

    initial begin
        int done_times[$];
        int n;
        bit saw_done;

        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        start  = 1'b0;
        BCD_In = 12'h000;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out", int'(Binary_Out), 0);
        check("rst_error", int'(error), 0);
        reset = 1'b0;

        convert(12'h999, 999, 1'b1, 1'b0, "h999");
        check("h999_hex", int'(Binary_Out), 'h3E7);
        check("model_999", m_out, 999);
        convert(12'h000, 0, 1'b1, 1'b0, "h000");
        convert(12'h255, 255, 1'b1, 1'b0, "h255");
        check("model_255", m_out, 255);
        convert(12'h1A0, 0, 1'b0, 1'b1, "h1A0");
        check("model_err", int'(m_err), 1);
        convert(12'h908, 908, 1'b1, 1'b0, "h908");
        convert(12'hF09, 0, 1'b0, 1'b1, "hF09");
        convert(12'h001, 1, 1'b1, 1'b0, "h001");

        // Start held high: back-to-back conversions every BIN_W+2 cycles
        @(negedge clk);
        BCD_In = 12'h123;
        start  = 1'b1;
        n = 0;
        while (done_times.size() < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (done) begin
                done_times.push_back(n);
                check("b2b_value", int'(Binary_Out), 123);
            end
        end
        check("b2b_count", done_times.size(), 3);
        if (done_times.size() == 3) begin
            check("b2b_gap1", done_times[1] - done_times[0], BIN_W + 2);
            check("b2b_gap2", done_times[2] - done_times[1], BIN_W + 2);
        end
        start = 1'b0;
        repeat (BIN_W + 3) @(negedge clk);

        // Reset during iteration 5 of a 512 conversion
        BCD_In = 12'h512;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_out", int'(Binary_Out), 0);
        check("abort_error", int'(error), 0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (BIN_W + 2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", int'(saw_done), 0);
        convert(12'h512, 512, 1'b1, 1'b0, "h512");

        // Exhaustive sweep of all valid three-digit inputs
        for (int v = 0; v < 1000; v++) begin
            logic [11:0] b;
            b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            convert(b, v, 1'b1, 1'b0, "sweep");
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bcd_to_binary_converter

// File: doc/bcd_to_binary_converter.md
BCD_TO_BINARY_CONVERTER -- requirements
Module: bcd_to_binary_converter

Interface
REQ-001 Parameter DIGITS, default 3, number of packed BCD digits at input.
REQ-002 Parameter BIN_W, default 10, binary result width; SHALL satisfy 2**BIN_W > 10**DIGITS - 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to convert BCD_In; sampled only in IDLE.
REQ-006 BCD_In  input  4*DIGITS  packed BCD, digit 0 in bits [3:0].
REQ-007 Binary_Out  output  BIN_W  registered binary result of the last completed conversion.
REQ-008 busy  output  1  high while a conversion is in progress (states SHIFT and DONE).
REQ-009 done  output  1  single-cycle pulse marking Binary_Out and error valid.
REQ-010 error  output  1  high if any digit of the captured BCD_In exceeded 9; valid with done.

Function
REQ-011 The block SHALL implement reverse double-dabble: a {bcd_reg, bin_reg} shift register of 4*DIGITS+BIN_W bits.
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 IDLE + start=1 at edge E: load bcd_reg<=BCD_In, bin_reg<=0, iteration count<=0, error_reg<=(any digit>9), next SHIFT.
REQ-014 IDLE + start=0: remain IDLE, all registers hold.
REQ-015 Each SHIFT edge SHALL shift {bcd_reg, bin_reg} right by one (zero into MSB), then subtract 3 from every resulting BCD digit >= 8, all within the same cycle.
REQ-016 SHIFT SHALL perform exactly BIN_W iterations, at edges E+1 through E+BIN_W; after the last one, next state is DONE.
REQ-017 At edge E+BIN_W, Binary_Out SHALL be loaded with the final bin_reg and error SHALL be loaded with error_reg.
REQ-018 done SHALL be high exactly in the cycle following edge E+BIN_W (state DONE); the FSM then returns to IDLE.
REQ-019 Latency from the start-sampling edge to done high: BIN_W+1 edges; throughput: one conversion per BIN_W+2 cycles.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored, neither queued nor restarting the conversion.
REQ-021 Binary_Out and error SHALL hold their values from completion until the next completion or reset.
REQ-022 On an invalid digit, conversion SHALL still run to completion. Binary_Out is then don't-care and error=1.
REQ-023 The iteration counter SHALL be $clog2(BIN_W+1) bits wide and SHALL not wrap during a conversion.

Reset
REQ-024 reset=1 at any edge SHALL force state IDLE and clear bcd_reg, bin_reg, the counter, Binary_Out, error, done and busy to 0.
REQ-025 Reset mid-conversion SHALL abort it; no done pulse is produced for the aborted request.
REQ-026 reset SHALL take priority over start in the same cycle.

Structure
REQ-027 Shared package bcd_conv_pkg SHALL hold the default DIGITS and BIN_W constants and the FSM state enum (IDLE, SHIFT, DONE).
REQ-028 The per-digit correction SHALL be a combinational sub-module bcd_sub_three_cell: 4-bit in, 4-bit out, in >= 8 -> in-3, else in.
REQ-029 bcd_sub_three_cell SHALL be instantiated DIGITS times via generate; the top holds the FSM and registers only.

Verification
REQ-030 BCD_In=12'h999, start pulse -> done after 11 edges, Binary_Out=10'd999 (10'h3E7), error=0.
REQ-031 BCD_In=12'h000 -> Binary_Out=0, error=0. BCD_In=12'h255 -> Binary_Out=10'd255.
REQ-032 BCD_In=12'h1A0 -> done pulses normally, error=1.
REQ-033 Start held high continuously with BCD_In=12'h123 -> conversions complete back-to-back every 12 cycles, each with Binary_Out=10'd123; no start accepted while busy.
REQ-034 Reset at iteration 5 of BCD_In=12'h512 -> no done pulse, all outputs 0 next cycle. A fresh start then yields 10'd512.
REQ-035 Exhaustive sweep 000..999 -> Binary_Out matches the decimal value for every input, error=0.
